// File: rtl/clock_time_set.sv
// clock_time_set
//   User-entry writer for the HH:MM:SS real-time clock. Conditions the
//   SET/UP/DOWN pushbuttons (2-flop sync + debounce), walks a field-select
//   state machine RUN -> hours -> minutes -> seconds -> RUN, and issues a
//   one-cycle LOAD strobe carrying the edited time for the counters.
//
//   Optional build macro: CLOCK_TIME_SET_AUTOREPEAT_EN
//     When defined, a held UP/DOWN repeats after REPEAT_DELAY cycles and
//     then every REPEAT_CYCLES cycles.
//
//   Ports
//     CLOCK_50          in   system clock, rising edge
//     RESETN            in   asynchronous active-low reset
//     SET_N/UP_N/DOWN_N in   raw pushbuttons, active-low, asynchronous
//     CUR_H/CUR_M/CUR_S in   running time (5/6/6 bits)
//     EDIT_MODE         out  high while a field is being edited
//     FIELD             out  0=RUN, 1=hours, 2=minutes, 3=seconds
//     BLINK             out  blink phase for the selected field
//     LOAD              out  one-cycle parallel-load strobe
//     LOAD_H/M/S        out  edited time (5/6/6 bits)
module clock_time_set #(
    parameter int unsigned DEB_CYCLES    = 500000,
    parameter int unsigned BLINK_CYCLES  = 12500000,
    parameter int unsigned REPEAT_DELAY  = 25000000,
    parameter int unsigned REPEAT_CYCLES = 5000000
) (
    input  logic       CLOCK_50,
    input  logic       RESETN,
    input  logic       SET_N,
    input  logic       UP_N,
    input  logic       DOWN_N,
    input  logic [4:0] CUR_H,
    input  logic [5:0] CUR_M,
    input  logic [5:0] CUR_S,
    output logic       EDIT_MODE,
    output logic [1:0] FIELD,
    output logic       BLINK,
    output logic       LOAD,
    output logic [4:0] LOAD_H,
    output logic [5:0] LOAD_M,
    output logic [5:0] LOAD_S
);

    localparam int unsigned DW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CYCLES - 1);
    localparam int unsigned BW = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_CYCLES - 1);

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        SET_HR  = 2'd1,
        SET_MIN = 2'd2,
        SET_SEC = 2'd3
    } state_t;

    // Button index: 0=SET, 1=UP, 2=DOWN
    logic [2:0]    sync1, sync2;   // raw polarity, '1 = released
    logic [2:0]    pressed_sync;
    logic [2:0]    deb;            // debounced level, 1 = pressed
    logic [DW-1:0] deb_cnt [3];
    logic [2:0]    press;

    state_t        state;
    logic          edit_q;
    logic          blink_q;
    logic [BW-1:0] blink_cnt;
    logic          load_q;
    logic [4:0]    lh;
    logic [5:0]    lm, ls;

    logic          rep_up, rep_dn;
    logic          set_ev, step_up, step_dn;

    // ------------------------------------------------------------------
    // Input conditioning
    // ------------------------------------------------------------------
    always_ff @(posedge CLOCK_50 or negedge RESETN) begin
        if (!RESETN) begin
            sync1 <= '1;
            sync2 <= '1;
        end else begin
            sync1 <= {DOWN_N, UP_N, SET_N};
            sync2 <= sync1;
        end
    end

    assign pressed_sync = ~sync2;

    always_ff @(posedge CLOCK_50 or negedge RESETN) begin
        if (!RESETN) begin
            deb <= '0;
            for (int unsigned i = 0; i < 3; i++) deb_cnt[i] <= '0;
        end else begin
            for (int unsigned i = 0; i < 3; i++) begin
                if (pressed_sync[i] != deb[i]) begin
                    if (deb_cnt[i] == DEB_LAST) begin
                        deb[i]     <= pressed_sync[i];
                        deb_cnt[i] <= '0;
                    end else begin
                        deb_cnt[i] <= deb_cnt[i] + 1'b1;
                    end
                end else begin
                    deb_cnt[i] <= '0;
                end
            end
        end
    end

    // Press fires in the cycle whose edge flips the debounced level, so the
    // FSM reacts on the same edge that commits the new level.
    always_comb begin
        press = '0;
        for (int unsigned i = 0; i < 3; i++)
            press[i] = pressed_sync[i] & ~deb[i] & (deb_cnt[i] == DEB_LAST);
    end

    // ------------------------------------------------------------------
    // Auto-repeat
    // ------------------------------------------------------------------
`ifdef CLOCK_TIME_SET_AUTOREPEAT_EN
    localparam int unsigned RMAX = (REPEAT_DELAY > REPEAT_CYCLES) ? REPEAT_DELAY : REPEAT_CYCLES;
    localparam int unsigned RW = (RMAX > 1) ? $clog2(RMAX) : 1;
    localparam logic [RW-1:0] RDLY_LAST = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] RCYC_LAST = RW'(REPEAT_CYCLES - 1);

    logic [RW-1:0] rep_cnt;
    logic          rep_periodic;
    logic          held_up, held_dn;
    logic [RW-1:0] rep_limit;
    logic          rep_fire;
    logic          rep_idle;

    assign held_up   = deb[1] & ~deb[2];
    assign held_dn   = deb[2] & ~deb[1];
    assign rep_limit = rep_periodic ? RCYC_LAST : RDLY_LAST;
    // A fresh press restarts the delay; holding both or neither disarms it.
    assign rep_idle  = (state == RUN) | press[1] | press[2] | ~(held_up | held_dn);
    assign rep_fire  = ~rep_idle & (rep_cnt == rep_limit);
    assign rep_up    = rep_fire & held_up;
    assign rep_dn    = rep_fire & held_dn;

    always_ff @(posedge CLOCK_50 or negedge RESETN) begin
        if (!RESETN) begin
            rep_cnt      <= '0;
            rep_periodic <= 1'b0;
        end else if (rep_idle) begin
            rep_cnt      <= '0;
            rep_periodic <= 1'b0;
        end else if (rep_cnt == rep_limit) begin
            rep_cnt      <= '0;
            rep_periodic <= 1'b1;
        end else begin
            rep_cnt <= rep_cnt + 1'b1;
        end
    end
`else
    logic unused_repeat_params;
    assign unused_repeat_params = ^{REPEAT_DELAY, REPEAT_CYCLES};
    assign rep_up = 1'b0;
    assign rep_dn = 1'b0;
`endif

    // SET has priority; UP and DOWN together cancel.
    assign set_ev  = press[0];
    assign step_up = (press[1] | rep_up) & ~(press[2] | rep_dn) & ~set_ev;
    assign step_dn = (press[2] | rep_dn) & ~(press[1] | rep_up) & ~set_ev;

    function automatic logic [4:0] hr_step(input logic [4:0] h, input logic up);
        if (up) return (h >= 5'd23) ? 5'd0 : h + 5'd1;
        else    return (h == 5'd0) ? 5'd23 : h - 5'd1;
    endfunction

    function automatic logic [5:0] ms_step(input logic [5:0] v, input logic up);
        if (up) return (v >= 6'd59) ? 6'd0 : v + 6'd1;
        else    return (v == 6'd0) ? 6'd59 : v - 6'd1;
    endfunction

    // ------------------------------------------------------------------
    // Field-select FSM, edit registers and blink
    // ------------------------------------------------------------------
    always_ff @(posedge CLOCK_50 or negedge RESETN) begin
        if (!RESETN) begin
            state     <= RUN;
            edit_q    <= 1'b0;
            load_q    <= 1'b0;
            lh        <= '0;
            lm        <= '0;
            ls        <= '0;
            blink_q   <= 1'b0;
            blink_cnt <= '0;
        end else begin
            load_q <= 1'b0;
            if (state == RUN) begin
                blink_q   <= 1'b0;
                blink_cnt <= '0;
                if (set_ev) begin
                    state   <= SET_HR;
                    edit_q  <= 1'b1;
                    blink_q <= 1'b1;
                    lh      <= (CUR_H > 5'd23) ? 5'd0 : CUR_H;
                    lm      <= (CUR_M > 6'd59) ? 6'd0 : CUR_M;
                    ls      <= (CUR_S > 6'd59) ? 6'd0 : CUR_S;
                end
            end else if (set_ev) begin
                blink_q   <= 1'b1;
                blink_cnt <= '0;
                case (state)
                    SET_HR:  state <= SET_MIN;
                    SET_MIN: state <= SET_SEC;
                    default: begin
                        state   <= RUN;
                        edit_q  <= 1'b0;
                        load_q  <= 1'b1;
                        blink_q <= 1'b0;
                    end
                endcase
            end else if (step_up | step_dn) begin
                blink_q   <= 1'b1;
                blink_cnt <= '0;
                case (state)
                    SET_HR:  lh <= hr_step(lh, step_up);
                    SET_MIN: lm <= ms_step(lm, step_up);
                    default: ls <= ms_step(ls, step_up);
                endcase
            end else if (blink_cnt == BLINK_LAST) begin
                blink_q   <= ~blink_q;
                blink_cnt <= '0;
            end else begin
                blink_cnt <= blink_cnt + 1'b1;
            end
        end
    end

    assign FIELD     = state;
    assign EDIT_MODE = edit_q;
    assign BLINK     = blink_q;
    assign LOAD      = load_q;
    assign LOAD_H    = lh;
    assign LOAD_M    = lm;
    assign LOAD_S    = ls;

endmodule

// File: tb/tb_clock_time_set.sv
// Testbench for clock_time_set (DEB_CYCLES=4, BLINK_CYCLES=8,
// REPEAT_DELAY=20, REPEAT_CYCLES=6). Honours CLOCK_TIME_SET_AUTOREPEAT_EN.
module tb_clock_time_set;

`ifdef CLOCK_TIME_SET_AUTOREPEAT_EN
    localparam bit AR = 1'b1;
`else
    localparam bit AR = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       set_n = 1'b1, up_n = 1'b1, down_n = 1'b1;
    logic [4:0] cur_h = '0;
    logic [5:0] cur_m = '0, cur_s = '0;
    logic       edit_mode, blink, load;
    logic [1:0] field;
    logic [4:0] load_h;
    logic [5:0] load_m, load_s;

    int checks = 0;
    int errors = 0;
    int load_count = 0;

    clock_time_set #(
        .DEB_CYCLES(4),
        .BLINK_CYCLES(8),
        .REPEAT_DELAY(20),
        .REPEAT_CYCLES(6)
    ) dut (
        .CLOCK_50(clk),
        .RESETN(rst_n),
        .SET_N(set_n),
        .UP_N(up_n),
        .DOWN_N(down_n),
        .CUR_H(cur_h),
        .CUR_M(cur_m),
        .CUR_S(cur_s),
        .EDIT_MODE(edit_mode),
        .FIELD(field),
        .BLINK(blink),
        .LOAD(load),
        .LOAD_H(load_h),
        .LOAD_M(load_m),
        .LOAD_S(load_s)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (load === 1'b1) load_count++;

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    typedef struct {
        logic [2:0] btn;   // bit0 SET, bit1 UP, bit2 DOWN
        int ch, cm, cs;
        int f, chk_b, b, h, m, s, loads;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic [2:0] btn, input int ch, input int cm, input int cs,
                                input int f, input int chk_b, input int b,
                                input int h, input int m, input int s, input int loads);
        vec_t v;
        v.btn = btn; v.ch = ch; v.cm = cm; v.cs = cs;
        v.f = f; v.chk_b = chk_b; v.b = b;
        v.h = h; v.m = m; v.s = s; v.loads = loads;
        return v;
    endfunction

    // Drive buttons 10 cycles; the step lands 6 edges after the drive.
    // blink_step is sampled right after the step; ends with buttons released
    // and debounced back.
    task automatic press(input logic [2:0] btn, output logic blink_step);
        @(posedge clk); #1;
        set_n = ~btn[0]; up_n = ~btn[1]; down_n = ~btn[2];
        repeat (6) @(posedge clk);
        @(negedge clk);
        blink_step = blink;
        repeat (4) @(posedge clk); #1;
        set_n = 1'b1; up_n = 1'b1; down_n = 1'b1;
        repeat (10) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(negedge clk);
        chk("rst field", int'(field), 0);
        chk("rst edit", int'(edit_mode), 0);
        chk("rst blink", int'(blink), 0);
        chk("rst lh", int'(load_h), 0);
        chk("rst lm", int'(load_m), 0);
        chk("rst ls", int'(load_s), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        logic bstep;
        int   lc;

        tbl.push_back(mk(3'b010, 12, 34, 56, 0, 1, 0,  0,  0,  0, 0));
        tbl.push_back(mk(3'b100, 12, 34, 56, 0, 1, 0,  0,  0,  0, 0));
        tbl.push_back(mk(3'b001, 12, 34, 56, 1, 1, 1, 12, 34, 56, 0));
        tbl.push_back(mk(3'b010, 12, 34, 56, 1, 1, 1, 13, 34, 56, 0));
        tbl.push_back(mk(3'b100, 12, 34, 56, 1, 1, 1, 12, 34, 56, 0));
        tbl.push_back(mk(3'b001, 12, 34, 56, 2, 1, 1, 12, 34, 56, 0));
        tbl.push_back(mk(3'b100, 12, 34, 56, 2, 1, 1, 12, 33, 56, 0));
        tbl.push_back(mk(3'b010, 12, 34, 56, 2, 1, 1, 12, 34, 56, 0));
        tbl.push_back(mk(3'b001, 12, 34, 56, 3, 1, 1, 12, 34, 56, 0));
        tbl.push_back(mk(3'b010, 12, 34, 56, 3, 1, 1, 12, 34, 57, 0));
        tbl.push_back(mk(3'b100, 12, 34, 56, 3, 1, 1, 12, 34, 56, 0));
        tbl.push_back(mk(3'b001, 12, 34, 56, 0, 1, 0, 12, 34, 56, 1));
        tbl.push_back(mk(3'b001, 23,  0, 59, 1, 1, 1, 23,  0, 59, 1));
        tbl.push_back(mk(3'b010, 23,  0, 59, 1, 1, 1,  0,  0, 59, 1));
        tbl.push_back(mk(3'b100, 23,  0, 59, 1, 1, 1, 23,  0, 59, 1));
        tbl.push_back(mk(3'b001, 23,  0, 59, 2, 1, 1, 23,  0, 59, 1));
        tbl.push_back(mk(3'b100, 23,  0, 59, 2, 1, 1, 23, 59, 59, 1));
        tbl.push_back(mk(3'b001, 23,  0, 59, 3, 1, 1, 23, 59, 59, 1));
        tbl.push_back(mk(3'b010, 23,  0, 59, 3, 1, 1, 23, 59,  0, 1));
        tbl.push_back(mk(3'b110, 23,  0, 59, 3, 0, 0, 23, 59,  0, 1));
        tbl.push_back(mk(3'b001, 23,  0, 59, 0, 1, 0, 23, 59,  0, 2));
        tbl.push_back(mk(3'b001,  5, 10, 20, 1, 1, 1,  5, 10, 20, 2));
        tbl.push_back(mk(3'b001,  5, 10, 20, 2, 1, 1,  5, 10, 20, 2));
        tbl.push_back(mk(3'b110,  5, 10, 20, 2, 0, 0,  5, 10, 20, 2));
        tbl.push_back(mk(3'b011,  5, 10, 20, 3, 1, 1,  5, 10, 20, 2));
        tbl.push_back(mk(3'b001,  5, 10, 20, 0, 1, 0,  5, 10, 20, 3));
        tbl.push_back(mk(3'b001, 31, 63, 60, 1, 1, 1,  0,  0,  0, 3));
        tbl.push_back(mk(3'b100, 31, 63, 60, 1, 1, 1, 23,  0,  0, 3));
        tbl.push_back(mk(3'b001, 31, 63, 60, 2, 1, 1, 23,  0,  0, 3));
        tbl.push_back(mk(3'b001, 31, 63, 60, 3, 1, 1, 23,  0,  0, 3));
        tbl.push_back(mk(3'b010, 31, 63, 60, 3, 1, 1, 23,  0,  1, 3));

        repeat (3) @(posedge clk);
        do_reset();

        foreach (tbl[i]) begin
            cur_h = 5'(tbl[i].ch); cur_m = 6'(tbl[i].cm); cur_s = 6'(tbl[i].cs);
            press(tbl[i].btn, bstep);
            if (tbl[i].chk_b != 0) chk($sformatf("vec%0d blink", i), int'(bstep), tbl[i].b);
            chk($sformatf("vec%0d field", i), int'(field), tbl[i].f);
            chk($sformatf("vec%0d edit", i), int'(edit_mode), (tbl[i].f != 0) ? 1 : 0);
            chk($sformatf("vec%0d h", i), int'(load_h), tbl[i].h);
            chk($sformatf("vec%0d m", i), int'(load_m), tbl[i].m);
            chk($sformatf("vec%0d s", i), int'(load_s), tbl[i].s);
            chk($sformatf("vec%0d loads", i), load_count, tbl[i].loads);
        end

        // Reset mid-edit in SET_SEC with a pending change
        lc = load_count;
        do_reset();
        repeat (10) @(posedge clk);
        @(negedge clk);
        chk("midrst field", int'(field), 0);
        chk("midrst loads", load_count, lc);

        // Debounce: 3 low, 1 high, 3 low -> no press
        cur_h = 5'd12; cur_m = 6'd34; cur_s = 6'd56;
        @(posedge clk); #1; set_n = 1'b0;
        repeat (3) @(posedge clk); #1; set_n = 1'b1;
        @(posedge clk); #1; set_n = 1'b0;
        repeat (3) @(posedge clk); #1; set_n = 1'b1;
        repeat (12) @(posedge clk);
        @(negedge clk);
        chk("bounce field", int'(field), 0);

        // Held 10 cycles: one transition, then blink timing
        @(posedge clk); #1; set_n = 1'b0;
        repeat (6) @(posedge clk);
        @(negedge clk);
        chk("hold field", int'(field), 1);
        chk("hold blink0", int'(blink), 1);
        repeat (4) @(posedge clk); #1; set_n = 1'b1;
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("blink toggle", int'(blink), 0);
        repeat (8) @(posedge clk);
        @(negedge clk);
        chk("blink toggle2", int'(blink), 1);
        chk("hold single", int'(field), 1);
        chk("hold lh", int'(load_h), 12);

        // Auto-repeat from SET_MIN with M=58
        do_reset();
        cur_h = 5'd0; cur_m = 6'd58; cur_s = 6'd0;
        press(3'b001, bstep);
        press(3'b001, bstep);
        chk("ar field", int'(field), 2);
        chk("ar m0", int'(load_m), 58);
        @(posedge clk); #1; up_n = 1'b0;
        repeat (6) @(posedge clk);
        @(negedge clk);
        chk("ar press", int'(load_m), 59);
        repeat (19) @(posedge clk);
        @(negedge clk);
        chk("ar before", int'(load_m), 59);
        @(posedge clk);
        @(negedge clk);
        chk("ar first", int'(load_m), AR ? 0 : 59);
        repeat (6) @(posedge clk);
        @(negedge clk);
        chk("ar second", int'(load_m), AR ? 1 : 59);
        repeat (14) @(posedge clk);
        @(negedge clk);
        chk("ar fourth", int'(load_m), AR ? 3 : 59);
        chk("ar h", int'(load_h), 0);
        #1; up_n = 1'b1;
        repeat (12) @(posedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
